// File: rtl/alu_pkg.sv
// Shared constants and types for the pipelined ALU: opcode encodings,
// default widths and the decoded-instruction bundle.
package alu_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int OPCODE_WIDTH_DEF   = 7;
    localparam int REG_ADDR_WIDTH_DEF = 3;

    localparam logic [OPCODE_WIDTH_DEF-1:0] ADD  = 7'h1;
    localparam logic [OPCODE_WIDTH_DEF-1:0] SUB  = 7'h2;
    localparam logic [OPCODE_WIDTH_DEF-1:0] AND  = 7'h3;
    localparam logic [OPCODE_WIDTH_DEF-1:0] OR   = 7'h4;
    localparam logic [OPCODE_WIDTH_DEF-1:0] XOR  = 7'h5;
    localparam logic [OPCODE_WIDTH_DEF-1:0] SADD = 7'h6;

    typedef struct packed {
        logic [OPCODE_WIDTH_DEF-1:0]   opcode;
        logic [REG_ADDR_WIDTH_DEF-1:0] rd;
        logic [REG_ADDR_WIDTH_DEF-1:0] rs1;
        logic [REG_ADDR_WIDTH_DEF-1:0] rs2;
    } instr_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file with r0 tied to zero, one synchronous write port and two
// asynchronous read ports that see a same-cycle write (write-through bypass).
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    input  logic [REG_ADDR_WIDTH-1:0] rs1,
    input  logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [DATA_WIDTH-1:0]     rdata1,
    output logic [DATA_WIDTH-1:0]     rdata2
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic                  wb_hit_en;

    assign wb_hit_en = wb_valid && (wb_rd != '0);

    always_comb begin
        regs_d = regs_q;
        if (wb_hit_en) begin
            regs_d[wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Bypass only for nonzero indices so r0 stays zero even when written.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (rs1 != '0) begin
            rdata1 = (wb_hit_en && wb_rd == rs1) ? wb_data : regs_q[rs1];
        end
        if (rs2 != '0) begin
            rdata2 = (wb_hit_en && wb_rd == rs2) ? wb_data : regs_q[rs2];
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU stage 1: valid/ready intake, operand fetch with writeback bypass, and
// the pipeline register feeding the ALU stage, kept coherent while stalled.
module alu_operand_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int OPCODE_WIDTH   = OPCODE_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OPCODE_WIDTH-1:0]   in_opcode,
    input  logic [REG_ADDR_WIDTH-1:0] in_rd,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs1,
    input  logic [REG_ADDR_WIDTH-1:0] in_rs2,
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPCODE_WIDTH-1:0]   out_opcode,
    output logic [DATA_WIDTH-1:0]     out_opA,
    output logic [DATA_WIDTH-1:0]     out_opB,
    output logic [REG_ADDR_WIDTH-1:0] out_rd,
    output logic                      out_illegal
);

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // ready never depends on valid of the same side, and an offered valid
    // with its payload is held by the sender until it is taken.

    logic [DATA_WIDTH-1:0]     rdata1, rdata2;
    logic                      accept, stalled;

    logic                      valid_q,   valid_d;
    logic [OPCODE_WIDTH-1:0]   opcode_q,  opcode_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,      rd_d;
    logic [REG_ADDR_WIDTH-1:0] rs1_q,     rs1_d;
    logic [REG_ADDR_WIDTH-1:0] rs2_q,     rs2_d;
    logic [DATA_WIDTH-1:0]     opa_q,     opa_d;
    logic [DATA_WIDTH-1:0]     opb_q,     opb_d;
    logic                      illegal_q, illegal_d;

    alu_regfile #(
        .DATA_WIDTH     (DATA_WIDTH),
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_valid (wb_valid),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .rdata1   (rdata1),
        .rdata2   (rdata2)
    );

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign stalled  = valid_q && !out_ready;

    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d   = 1'b1;
            opcode_d  = in_opcode;
            rd_d      = in_rd;
            rs1_d     = in_rs1;
            rs2_d     = in_rs2;
            opa_d     = rdata1;
            opb_d     = rdata2;
            illegal_d = (in_opcode == '0) || (in_opcode > OPCODE_WIDTH'(SADD));
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end else if (stalled && wb_valid && wb_rd != '0) begin
            // A held operand must track writes to its source register.
            if (wb_rd == rs1_q) opa_d = wb_data;
            if (wb_rd == rs2_q) opb_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            opcode_q  <= '0;
            rd_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_opcode  = opcode_q;
    assign out_opA     = opa_q;
    assign out_opB     = opb_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Stage 1 of the 3-stage pipelined ALU. Accepts decoded instructions over a valid/ready handshake and reads two source operands from an internal 8-entry register file, with bypass from the writeback port. It registers opcode, operands and destination into a pipeline register that drives the ALU stage directly. It also absorbs writeback-stage results into the register file and keeps held operands coherent while the downstream stalls.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_WIDTH, 7, opcode width (matches ALU)
- REG_ADDR_WIDTH, 3, register index width (2**REG_ADDR_WIDTH registers)

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept this cycle
- in_opcode  in  OPCODE_WIDTH  operation code
- in_rd  in  REG_ADDR_WIDTH  destination register
- in_rs1  in  REG_ADDR_WIDTH  source A register
- in_rs2  in  REG_ADDR_WIDTH  source B register
- wb_valid  in  1  writeback strobe from stage 3
- wb_rd  in  REG_ADDR_WIDTH  writeback register
- wb_data  in  DATA_WIDTH  writeback value
- out_valid  out  1  pipeline register holds an instruction
- out_ready  in  1  ALU stage consumes this cycle
- out_opcode  out  OPCODE_WIDTH  to ALU opcode
- out_opA  out  DATA_WIDTH  to ALU opA
- out_opB  out  DATA_WIDTH  to ALU opB
- out_rd  out  REG_ADDR_WIDTH  destination, forwarded down the pipe
- out_illegal  out  1  opcode not in {1..6}

## Operation
- Register file: r0 reads 0 always; writes to r0 are ignored. r1..r7 are written on the clk edge when wb_valid=1.
- Operand read: async read of rs1/rs2. If wb_valid=1, wb_rd==rsX and rsX!=0, wb_data is used (write-through bypass).
- in_ready = !out_valid || out_ready (combinational, no bubble).
- Accept = in_valid && in_ready. On accept, the pipeline register loads:
  - opcode, rd
  - bypassed opA/opB
  - held rs1/rs2 indices
  - illegal = (opcode==0 || opcode>6)
- out_valid: set on accept. Cleared when out_ready=1 and no accept in the same cycle.
- Stall coherence: while out_valid=1 and out_ready=0, a wb_valid write to a nonzero held rs1 (rs2) index replaces out_opA (out_opB) with wb_data at that edge. Both operands update if rs1==rs2.
- Illegal opcodes are still issued. The ALU produces 0 for them; out_illegal flags them for stage 3.
- Held outputs do not change while stalled, except through stall coherence.

## Timing
- Latency: accept at edge N gives out_valid=1 after edge N. Throughput is 1 instruction/cycle when out_ready=1.
- Reset (rst_n=0 at an edge): out_valid=0, out_opcode=0, out_opA=0, out_opB=0, out_rd=0, out_illegal=0, all registers 0. in_ready=1 after reset.
- Reset mid-operation discards the held instruction; no partial state survives.
- Simultaneous accept and writeback to a source register: the new instruction sees wb_data. The register file is updated at the same edge.
- Simultaneous consume (out_ready=1) and accept: the new instruction replaces the old one with no gap.
- Writeback is never back-pressured; wb_valid is honoured every cycle, including during stall and reset deassertion.

## Structure
- Package alu_pkg holds:
  - opcode constants ADD=7'h1, SUB=7'h2, AND=7'h3, OR=7'h4, XOR=7'h5, SADD=7'h6
  - default width constants
  - packed instruction struct {opcode, rd, rs1, rs2}
- Sub-module alu_regfile: 2**REG_ADDR_WIDTH x DATA_WIDTH, one sync write port, two async read ports, r0 hardwired zero, bypass inside.
- Top level holds the handshake and pipeline register.

## Test plan
- Reset, then wb writes r1=5, r2=3. Issue ADD rd=3 rs1=1 rs2=2 -> next cycle out_valid=1, opA=5, opB=3, opcode=1, out_illegal=0.
- Same-cycle bypass: wb_valid r4=0xDEADBEEF while issuing XOR rs1=4 rs2=0 -> opA=0xDEADBEEF, opB=0.
- Stall coherence: hold out_ready=0 with SUB rs1=1 (opA=5) held, then wb r1=9 -> opA becomes 9. in_ready=0 throughout the stall. Release -> one transfer.
- Back-to-back: 4 instructions with out_ready=1 -> 4 consecutive out_valid cycles in order. Random out_ready -> no loss or duplication.
- Write r0=7, issue OR rs1=0 -> opA=0. Issue opcode 7'h9 -> out_illegal=1, instruction still issued.
- Assert rst_n=0 while stalled with valid data -> all outputs 0 at next edge, registers read 0 afterwards.
